// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin controller for a shared W-bit ALU.
// Each op walks IDLE -> EXEC -> DONE and may update the ZF/SF/OF register.
// Requester 0 is the OPq execute path; requester 1 is address/rsp arithmetic.
module alu_arbiter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_fun,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_setcc,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_fun,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_setcc,
  // responses
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_data,
  // condition codes
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] FUN_ADD = 2'd0;
  localparam logic [1:0] FUN_SUB = 2'd1;
  localparam logic [1:0] FUN_AND = 2'd2;
  localparam logic [1:0] FUN_XOR = 2'd3;

  state_t       state_q;
  logic         rrLast_q;
  logic         owner_q;
  logic [1:0]   fun_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         setcc_q;
  logic [W-1:0] data_q;
  logic         rsp0Valid_q;
  logic         rsp1Valid_q;
  logic         zf_q;
  logic         sf_q;
  logic         of_q;

  logic         grant0;
  logic         grant1;
  logic [1:0]   fun_d;
  logic [W-1:0] a_d;
  logic [W-1:0] b_d;
  logic         setcc_d;
  logic [W-1:0] aluResult;
  logic         aluOf;
  logic         handshake;

  // Grant in IDLE only; on a tie the requester not granted last time wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = rrLast_q;
        grant1 = ~rrLast_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Readies are forced low while reset is held, since the FSM already sits in IDLE then.
  assign req0_ready = rst_n & grant0;
  assign req1_ready = rst_n & grant1;

  // Select the winning requester's fields for capture at accept time.
  always_comb begin
    fun_d   = req0_fun;
    a_d     = req0_a;
    b_d     = req0_b;
    setcc_d = req0_setcc;
    if (grant1) begin
      fun_d   = req1_fun;
      a_d     = req1_a;
      b_d     = req1_b;
      setcc_d = req1_setcc;
    end
  end

  // Shared ALU on the latched operands; carry out is discarded, OF only for add/sub.
  always_comb begin
    aluResult = '0;
    aluOf     = 1'b0;
    unique case (fun_q)
      FUN_ADD: begin
        aluResult = a_q + b_q;
        aluOf     = (a_q[W-1] == b_q[W-1]) && (aluResult[W-1] != a_q[W-1]);
      end
      FUN_SUB: begin
        aluResult = a_q - b_q;
        aluOf     = (a_q[W-1] != b_q[W-1]) && (aluResult[W-1] != a_q[W-1]);
      end
      FUN_AND: aluResult = a_q & b_q;
      FUN_XOR: aluResult = a_q ^ b_q;
      default: aluResult = '0;
    endcase
  end

  // Response completes only when the owner's ready meets its own valid.
  assign handshake = (rsp0Valid_q && rsp0_ready) || (rsp1Valid_q && rsp1_ready);

  // Sequencer: accept -> execute/register result and flags -> hold response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rrLast_q    <= 1'b1;
      owner_q     <= 1'b0;
      fun_q       <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      setcc_q     <= 1'b0;
      data_q      <= '0;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            owner_q  <= grant1;
            rrLast_q <= grant1;
            fun_q    <= fun_d;
            a_q      <= a_d;
            b_q      <= b_d;
            setcc_q  <= setcc_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          data_q      <= aluResult;
          rsp0Valid_q <= ~owner_q;
          rsp1Valid_q <= owner_q;
          if (setcc_q) begin
            zf_q <= (aluResult == '0);
            sf_q <= aluResult[W-1];
            of_q <= aluOf;
          end
          state_q <= DONE;
        end
        DONE: begin
          if (handshake) begin
            rsp0Valid_q <= 1'b0;
            rsp1Valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp0_valid = rsp0Valid_q;
  assign rsp1_valid = rsp1Valid_q;
  assign rsp_data   = data_q;
  assign cc_zf      = zf_q;
  assign cc_sf      = sf_q;
  assign cc_of      = of_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shared-ALU controller for the Y86 execute stage. It arbitrates between two requesters for one 64-bit ALU datapath built from the team's add/sub/and/xor units, and sequences each operation through accept, execute and respond phases. It also owns the architectural condition-code register (ZF/SF/OF). Requester 0 is the OPq execute path; requester 1 is the address/stack-pointer arithmetic path.

## Interface
- W, 64, operand/result width; flag logic uses bit W-1 as sign
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request present, N ∈ {0,1}
- reqN_ready  out  1  request accepted this cycle
- reqN_fun  in  2  0=add, 1=sub (a−b), 2=and, 3=xor
- reqN_a, reqN_b  in  W  operands
- reqN_setcc  in  1  update CC with this op's flags
- rspN_valid  out  1  result available for requester N
- rspN_ready  in  1  requester N takes result
- rsp_data  out  W  result, shared by both response ports
- cc_zf, cc_sf, cc_of  out  1  condition-code register

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state: IDLE.
- IDLE:
  - reqN_ready = 1 only for the granted requester, combinational on the valids and the rr pointer; the other ready = 0.
  - On valid&ready: latch fun, a, b, setcc and owner id; go to EXEC.
  - If no valid: stay in IDLE.
- Arbitration:
  - Single valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - rr pointer updates on every accept. Reset value: 1, so req0 wins the first tie.
- EXEC:
  - Compute the result from the latched operands and register it into rsp_data.
  - If the latched setcc = 1, register the flags into the CC register.
  - Go to DONE unconditionally.
- Arithmetic is modulo 2^W; carry is discarded.
- Flags:
  - ZF = (result == 0); SF = result[W-1].
  - OF for add = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]).
  - OF for sub = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]).
  - OF for and/xor = 0.
- DONE:
  - rspN_valid = 1 for the owner only.
  - rsp_data and rspN_valid hold stable until rspN_ready = 1.
  - On handshake: go to IDLE. Readies stay 0 during that handshake cycle; no same-cycle re-accept.
- setcc = 0: CC register unchanged.
- Requester 1 normally drives setcc = 0. The block does not enforce this.
- Requests arriving outside IDLE see ready = 0 and must hold; no queuing.
- rspN_ready while rspN_valid = 0: ignored.
- Reset values: rsp0_valid = rsp1_valid = 0, rsp_data = 0, cc_zf = 1, cc_sf = 0, cc_of = 0, req0_ready = req1_ready = 0 while rst_n is low.
- Reset mid-operation: the in-flight op is discarded, no response is issued, the CC register is restored to reset values, and the FSM returns to IDLE.

## Timing
- Accept at rising edge k (valid&ready sampled high).
- EXEC occupies cycle k→k+1.
- rsp_data, CC and rspN_valid update at edge k+1.
- Latency accept→rsp_valid: 1 clock.
- Minimum issue interval: 3 clocks (IDLE, EXEC, DONE with rsp_ready already high).
- CC update is visible from edge k+1, the same edge as rsp_valid.
- reqN_ready is combinational. The requester must hold valid and operands stable until ready.
- rsp backpressure of M cycles extends the interval to 3+M clocks.
- Assertion and release of rst_n are asynchronous. Outputs go to reset values immediately.

## Test plan
- Req0 fun=2, a=0x13, b=0x0A, setcc=1 -> rsp0_valid one clock after accept, rsp_data=0x2, ZF=0 SF=0 OF=0, rsp1_valid stays 0.
- Req0 fun=0, a=0x7FFF_FFFF_FFFF_FFFF, b=1, setcc=1 -> rsp_data=0x8000_0000_0000_0000, ZF=0 SF=1 OF=1. Then fun=1, a=5, b=5, setcc=1 -> rsp_data=0, ZF=1 SF=0 OF=0.
- Both valid continuously, three ops each -> first grant req0, then alternation req1, req0, req1, … Each rsp goes only to its owner. Issue interval is 3 clocks with rsp_ready held high.
- Req1 fun=3, a=0xFF, b=0x0F, setcc=0, with CC preset to Z=1 S=0 O=0 -> rsp_data=0xF0, CC unchanged. Hold rsp1_ready low 4 clocks -> rsp1_valid and rsp_data stable, req0_ready=0 throughout.
- Req0 accepted, then rst_n pulsed low during EXEC -> no rsp0_valid, CC reads Z=1 S=0 O=0, FSM in IDLE. The next req0 add 2+3 returns 5.
- Reset release with req0_valid already high -> req0_ready=1 in the first cycle after release; accepted op completes normally.
